led_pattern_sequencer: RTL and testbench

Avalon-MM controller that drives the 8-bit LED PIO output register through its s1 slave port. It steps through a programmable table of up to 8 LED patterns at a programmable rate, in looping or one-shot mode. It also forwards direct host LED writes whenever the sequencer is idle. It sits between the host-side Avalon interconnect (config slave) and the LED PIO (master port, address 0 = data register).

---
 rtl/led_pattern_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer: host config slave plus a write-only master that
// drives the LED PIO data register from a pattern table or from direct host writes.
module led_pattern_sequencer #(
    parameter int PATTERN_DEPTH = 8,
    parameter int PERIOD_WIDTH  = 24,
    parameter int PIO_WIDTH     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy,
    output logic        done_irq
);

    localparam int         IDX_W   = $clog2(PATTERN_DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(PATTERN_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic                    enable_q, enable_d;
    logic                    enable_prev_q;
    logic                    oneshot_q, oneshot_d;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [3:0]              length_q;
    logic                    done_q, done_d;
    logic [PIO_WIDTH-1:0]    direct_q;
    logic [PIO_WIDTH-1:0]    pat_q [PATTERN_DEPTH];
    logic [IDX_W-1:0]        index_q, index_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    fwd_q, fwd_d;
    logic [PIO_WIDTH-1:0]    last_q;

    logic                    wr_en, wr_ctrl, wr_period, wr_length, wr_status, wr_direct, wr_tab;
    logic                    tab_hit;
    logic [IDX_W-1:0]        tab_addr;
    logic                    host_enable, start, complete, last_step, strobe;
    logic [4:0]              len_eff;
    logic [PERIOD_WIDTH-1:0] period_load;
    logic [PIO_WIDTH-1:0]    pio_data;
    logic                    unused_wdata;

    assign unused_wdata = ^writedata;

    // Host slave decode
    assign wr_en     = chipselect && !write_n;
    assign tab_hit   = address[4] && ({1'b0, address[3:0]} < DEPTH_L);
    assign tab_addr  = address[IDX_W-1:0];
    assign wr_ctrl   = wr_en && (address == 5'd0);
    assign wr_period = wr_en && (address == 5'd1);
    assign wr_length = wr_en && (address == 5'd2);
    assign wr_status = wr_en && (address == 5'd3);
    assign wr_direct = wr_en && (address == 5'd4);
    assign wr_tab    = wr_en && tab_hit;

    // LENGTH of 0 runs one entry; oversize values clamp to the table depth.
    assign len_eff     = (length_q == 4'd0) ? 5'd1 :
                         ({1'b0, length_q} > DEPTH_L) ? DEPTH_L : {1'b0, length_q};
    assign period_load = (period_q == '0) ? '0 : period_q - PERIOD_WIDTH'(1);
    assign last_step   = (5'(index_q) == (len_eff - 5'd1));

    // A host clear of enable must win over a step that is about to fire this cycle.
    assign host_enable = wr_ctrl ? writedata[0] : enable_q;
    assign start       = (state_q == S_IDLE) && enable_q && !enable_prev_q && host_enable;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = period_load;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (last_step && oneshot_q) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        index_d = last_step ? '0 : index_q + IDX_W'(1);
                        state_d = S_WRITE;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && !host_enable) begin
            state_d = S_IDLE;
        end
    end

    assign enable_d  = complete ? 1'b0 : host_enable;
    assign oneshot_d = wr_ctrl ? writedata[1] : oneshot_q;
    assign done_d    = complete ? 1'b1 : ((wr_status && writedata[1]) ? 1'b0 : done_q);
    // Direct writes are forwarded only when the sequencer is idle and not starting.
    assign fwd_d     = wr_direct && (state_q == S_IDLE) && !start;

    assign strobe   = (state_q == S_WRITE) || fwd_q;
    assign pio_data = (state_q == S_WRITE) ? pat_q[index_q] : (fwd_q ? direct_q : last_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            enable_q      <= 1'b0;
            enable_prev_q <= 1'b0;
            oneshot_q     <= 1'b0;
            period_q      <= '0;
            length_q      <= '0;
            done_q        <= 1'b0;
            direct_q      <= '0;
            index_q       <= '0;
            cnt_q         <= '0;
            fwd_q         <= 1'b0;
            last_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q       <= state_d;
            enable_q      <= enable_d;
            enable_prev_q <= enable_q;
            oneshot_q     <= oneshot_d;
            done_q        <= done_d;
            index_q       <= index_d;
            cnt_q         <= cnt_d;
            fwd_q         <= fwd_d;
            if (wr_period) period_q <= writedata[PERIOD_WIDTH-1:0];
            if (wr_length) length_q <= writedata[3:0];
            if (wr_direct) direct_q <= writedata[PIO_WIDTH-1:0];
            if (strobe)    last_q   <= pio_data;
        end
    end

    // NOTE: the pattern table is reset because host reads of it must return 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PATTERN_DEPTH; i++) pat_q[i] <= '0;
        end else if (wr_tab) begin
            pat_q[tab_addr] <= writedata[PIO_WIDTH-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            5'd0:    readdata = {30'b0, oneshot_q, enable_q};
            5'd1:    readdata = 32'(period_q);
            5'd2:    readdata = {28'b0, length_q};
            5'd3:    readdata = {24'b0, 4'(index_q), 2'b0, done_q, busy};
            5'd4:    readdata = 32'(direct_q);
            default: if (tab_hit) readdata = 32'(pat_q[tab_addr]);
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done_irq     = done_q;
    assign m_address    = 2'd0;
    assign m_chipselect = strobe;
    assign m_write_n    = !strobe;
    assign m_writedata  = 32'(pio_data);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: a monitor logs every PIO strobe with its
// cycle number, and the directed sequence compares the log against hand-derived values.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        busy;
    logic        done_irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int proto_bad = 0;
    int          wr_cyc [$];
    logic [31:0] wr_dat [$];

    led_pattern_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .busy         (busy),
        .done_irq     (done_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_chipselect === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(m_writedata);
        end
        if (m_write_n !== ~m_chipselect) proto_bad++;
        if (m_address !== 2'd0) proto_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the write is captured.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 5'd0;
        writedata  = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        address    = 5'd0;
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_dat.delete();
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        int          n;
        int          hits;
        logic [7:0]  exp_loop [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02};
        logic [7:0]  exp_wrap [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        reset_n    = 1'b0;
        address    = 5'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_cs", {31'b0, m_chipselect}, 32'd0);
        check("rst_wn", {31'b0, m_write_n}, 32'd1);
        check("rst_wdata", m_writedata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done_irq}, 32'd0);
        for (int a = 0; a < 24; a++) begin
            rd(5'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'd0);
        end

        // Looping run: 01,02,04,08 with PERIOD=3 -> 4 clocks between writes
        wr(5'd16, 32'h01);
        wr(5'd17, 32'h02);
        wr(5'd18, 32'h04);
        wr(5'd19, 32'h08);
        wr(5'd2, 32'd4);
        wr(5'd1, 32'd3);
        rd(5'd18, d);
        check("tab_rd18", d, 32'h04);
        clear_log();
        wr(5'd0, 32'h1);
        repeat (26) @(negedge clk);
        check("loop_busy", {31'b0, busy}, 32'd1);
        rd(5'd3, d);
        check("loop_status_busy", d & 32'h3, 32'h1);
        check("loop_cnt_ge6", {31'b0, wr_dat.size() >= 6}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("loop_dat%0d", i), wr_dat[i], {24'b0, exp_loop[i]});
        end
        for (int i = 1; i < 6; i++) begin
            check($sformatf("loop_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 32'd4);
        end
        wr(5'd0, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        n = wr_dat.size();
        repeat (10) @(negedge clk);
        check("abort_no_more", wr_dat.size(), n);

        // One-shot run: exactly four writes, then done_irq and enable cleared
        clear_log();
        wr(5'd0, 32'h3);
        repeat (24) @(negedge clk);
        check("os_count", wr_dat.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("os_dat%0d", i), wr_dat[i], {24'b0, exp_loop[i]});
        end
        check("os_busy", {31'b0, busy}, 32'd0);
        check("os_done", {31'b0, done_irq}, 32'd1);
        rd(5'd0, d);
        check("os_ctrl", d, 32'h2);
        rd(5'd3, d);
        check("os_status", d & 32'h3, 32'h2);
        wr(5'd3, 32'h2);
        check("os_done_clr", {31'b0, done_irq}, 32'd0);

        // DIRECT while idle: one strobe in the cycle after the write
        clear_log();
        wr(5'd4, 32'hA5);
        c = cyc;
        repeat (3) @(negedge clk);
        check("dir_count", wr_dat.size(), 32'd1);
        check("dir_dat", wr_dat[0], 32'h0000_00A5);
        check("dir_cyc", wr_cyc[0], c);

        // DIRECT while busy: register updated, nothing forwarded
        clear_log();
        wr(5'd0, 32'h1);
        repeat (3) @(negedge clk);
        check("dirb_busy", {31'b0, busy}, 32'd1);
        wr(5'd4, 32'h5A);
        repeat (8) @(negedge clk);
        hits = 0;
        foreach (wr_dat[i]) if (wr_dat[i] == 32'h5A) hits++;
        check("dirb_no_fwd", hits, 32'd0);
        rd(5'd4, d);
        check("dirb_reg", d, 32'h5A);
        wr(5'd0, 32'h0);

        // DIRECT in the cycle the enable edge is seen: sequencer wins
        repeat (2) @(negedge clk);
        clear_log();
        wr(5'd0, 32'h1);
        wr(5'd4, 32'h3C);
        repeat (8) @(negedge clk);
        hits = 0;
        foreach (wr_dat[i]) if (wr_dat[i] == 32'h3C) hits++;
        check("dir_start_no_fwd", hits, 32'd0);
        check("dir_start_first", wr_dat[0], 32'h01);
        wr(5'd0, 32'h0);

        // PERIOD=0 and LENGTH=0 behave as 1: table[0] every 2 clocks
        wr(5'd1, 32'd0);
        wr(5'd2, 32'd0);
        clear_log();
        wr(5'd0, 32'h1);
        repeat (12) @(negedge clk);
        check("p0_cnt_ge5", {31'b0, wr_dat.size() >= 5}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("p0_dat%0d", i), wr_dat[i], 32'h01);
        end
        check("p0_gap1", wr_cyc[1] - wr_cyc[0], 32'd2);
        check("p0_gap4", wr_cyc[4] - wr_cyc[3], 32'd2);
        wr(5'd0, 32'h0);

        // LENGTH=12 clamps to depth 8: index wraps after entry 7
        wr(5'd20, 32'h10);
        wr(5'd21, 32'h20);
        wr(5'd22, 32'h40);
        wr(5'd23, 32'h80);
        wr(5'd2, 32'd12);
        wr(5'd1, 32'd1);
        clear_log();
        wr(5'd0, 32'h1);
        repeat (22) @(negedge clk);
        check("wrap_cnt_ge9", {31'b0, wr_dat.size() >= 9}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("wrap_dat%0d", i), wr_dat[i], {24'b0, exp_wrap[i]});
        end
        wr(5'd0, 32'h0);

        // Clear enable during WAIT: idle next clock, no further writes
        wr(5'd1, 32'd5);
        repeat (2) @(negedge clk);
        clear_log();
        wr(5'd0, 32'h1);
        repeat (3) @(negedge clk);
        check("cw_one_write", wr_dat.size(), 32'd1);
        check("cw_busy", {31'b0, busy}, 32'd1);
        wr(5'd0, 32'h0);
        check("cw_idle", {31'b0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("cw_no_more", wr_dat.size(), 32'd1);

        // Asynchronous reset during WAIT
        repeat (2) @(negedge clk);
        wr(5'd0, 32'h1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        clear_log();
        check("ar_busy", {31'b0, busy}, 32'd0);
        check("ar_cs", {31'b0, m_chipselect}, 32'd0);
        check("ar_wn", {31'b0, m_write_n}, 32'd1);
        check("ar_wdata", m_writedata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("ar_no_writes", wr_dat.size(), 32'd0);
        rd(5'd3, d);
        check("ar_status", d, 32'd0);
        rd(5'd0, d);
        check("ar_ctrl", d, 32'd0);
        rd(5'd1, d);
        check("ar_period", d, 32'd0);

        check("proto_wn_addr", proto_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
